// File: rtl/mario_sprite_renderer_pkg.sv
// mario_sprite_pkg: shared sprite geometry, key colour and animation frame encoding
package mario_sprite_pkg;

    localparam int          SPR_W       = 21;
    localparam int          SPR_H       = 41;
    localparam int          ADDR_W      = 10;
    localparam logic [23:0] TRANSPARENT = 24'h800080;

    // Encoding doubles as the frame-ROM select value
    typedef enum logic [1:0] {
        STAND  = 2'd0,
        WALK_A = 2'd1,
        WALK_B = 2'd2,
        JUMP   = 2'd3
    } anim_state_t;

endpackage

// File: rtl/mario_sprite_renderer_anim_fsm.sv
// mario_anim_fsm: per-video-frame walk/jump animation state, advancing only on frame_tick
module mario_anim_fsm
    import mario_sprite_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic        walking,
    input  logic        airborne,
    output anim_state_t o_state
);

    logic [7:0] r_step_cnt;

    // Jump wins over walking; walk frames alternate every FRAMES_PER_STEP ticks
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            o_state    <= STAND;
            r_step_cnt <= '0;
        end else if (frame_tick) begin
            if (airborne) begin
                o_state    <= JUMP;
                r_step_cnt <= '0;
            end else if (!walking) begin
                o_state    <= STAND;
                r_step_cnt <= '0;
            end else if (o_state == STAND || o_state == JUMP) begin
                o_state    <= WALK_A;
                r_step_cnt <= '0;
            end else if (r_step_cnt == 8'(FRAMES_PER_STEP - 1)) begin
                o_state    <= (o_state == WALK_A) ? WALK_B : WALK_A;
                r_step_cnt <= '0;
            end else begin
                r_step_cnt <= r_step_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/mario_sprite_renderer.sv
// mario_sprite_renderer: two-stage sprite hit/ROM-address and colour-key pipeline (optional MARIO_FLIP_EN mirrors columns)
module mario_sprite_renderer
    import mario_sprite_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 6
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_tick,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [9:0]  mario_x,
    input  logic [9:0]  mario_y,
    input  logic        walking,
    input  logic        airborne,
    input  logic        facing_left,
    output logic [9:0]  rom_address,
    output logic [1:0]  rom_sel,
    input  logic [23:0] rom_color,
    output logic        sprite_on,
    output logic [23:0] sprite_rgb
);

    logic [9:0]  r_px, r_py;
    logic        r_face;
    logic        r_hit;
    anim_state_t w_state;
    logic [10:0] w_x_end, w_y_end;
    logic [9:0]  w_dx, w_dy, w_col, w_addr;
    logic        w_hit, w_show;

    mario_anim_fsm #(.FRAMES_PER_STEP(FRAMES_PER_STEP)) u_fsm (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .walking    (walking),
        .airborne   (airborne),
        .o_state    (w_state)
    );

    // 11-bit box ends so a sprite near the right/bottom edge clips instead of wrapping
    assign w_x_end = {1'b0, r_px} + 11'(SPR_W);
    assign w_y_end = {1'b0, r_py} + 11'(SPR_H);
    assign w_hit   = DrawX >= r_px && {1'b0, DrawX} < w_x_end && DrawY >= r_py && {1'b0, DrawY} < w_y_end;
    assign w_dx    = DrawX - r_px;
    assign w_dy    = DrawY - r_py;
`ifdef MARIO_FLIP_EN
    assign w_col   = r_face ? 10'(SPR_W - 1) - w_dx : w_dx;
`else
    assign w_col   = w_dx;
`endif
    assign w_addr  = w_dy * 10'(SPR_W) + w_col;
    assign w_show  = r_hit && rom_color != TRANSPARENT;

    // Position/direction frozen between frame ticks so a frame never tears
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_px   <= '0;
            r_py   <= '0;
            r_face <= 1'b0;
        end else if (frame_tick) begin
            r_px   <= mario_x;
            r_py   <= mario_y;
            r_face <= facing_left;
        end
    end

    // Stage 1: box hit and ROM address/frame select
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_hit       <= 1'b0;
            rom_address <= '0;
            rom_sel     <= STAND;
        end else begin
            r_hit       <= w_hit;
            rom_address <= w_hit ? w_addr : '0;
            rom_sel     <= w_state;
        end
    end

    // Stage 2: key out the transparent palette entry
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sprite_on  <= 1'b0;
            sprite_rgb <= '0;
        end else begin
            sprite_on  <= w_show;
            sprite_rgb <= w_show ? rom_color : '0;
        end
    end

endmodule

// File: tb/tb_mario_sprite_renderer.sv
// tb_mario_sprite_renderer: directed + randomized checks against a frame-level behavioural model
module tb_mario_sprite_renderer;

    localparam logic [23:0] TR  = 24'h800080;
    localparam int          FPS = 6;

    logic        Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0, mario_x = '0, mario_y = '0;
    logic        walking = 1'b0, airborne = 1'b0, facing_left = 1'b0;
    logic [9:0]  rom_address;
    logic [1:0]  rom_sel;
    logic [23:0] rom_color;
    logic        sprite_on;
    logic [23:0] sprite_rgb;

    logic        ovr_en  = 1'b0;
    logic [23:0] ovr_col = '0;

    int n_pass = 0, n_tot = 0;

    // Behavioural model state
    int m_px = 0, m_py = 0, m_walk_n = 0, m_state = 0;
    bit m_face = 0;
    bit p_hit = 0;
    int p_addr = 0, p_sel = 0;

    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_base(input logic [9:0] a, input logic [1:0] s);
        return (a % 7 == 3) ? TR : {s, 12'hA5C, a};
    endfunction

    assign rom_color = ovr_en ? ovr_col : rom_base(rom_address, rom_sel);

    mario_sprite_renderer #(.FRAMES_PER_STEP(FPS)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .mario_x     (mario_x),
        .mario_y     (mario_y),
        .walking     (walking),
        .airborne    (airborne),
        .facing_left (facing_left),
        .rom_address (rom_address),
        .rom_sel     (rom_sel),
        .rom_color   (rom_color),
        .sprite_on   (sprite_on),
        .sprite_rgb  (sprite_rgb)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic int model_color(input int a, input int s);
        return ovr_en ? int'(ovr_col) : int'(rom_base(10'(a), 2'(s)));
    endfunction

    // One clock: predict from the rules, then compare every output
    task automatic step();
        int dx, dy, col, e_addr, e_sel;
        bit hit, e_on;
        logic [23:0] e_rgb;
        @(posedge Clk);
        dx  = int'(DrawX);
        dy  = int'(DrawY);
        hit = dx >= m_px && dx < m_px + 21 && dy >= m_py && dy < m_py + 41;
        col = dx - m_px;
`ifdef MARIO_FLIP_EN
        if (m_face) col = 20 - col;
`endif
        e_addr = hit ? (dy - m_py) * 21 + col : 0;
        e_sel  = m_state;
        e_on   = p_hit && model_color(p_addr, p_sel) != int'(TR);
        e_rgb  = e_on ? 24'(model_color(p_addr, p_sel)) : 24'h0;
        p_hit  = hit;
        p_addr = e_addr;
        p_sel  = e_sel;
        if (frame_tick) begin
            m_px   = int'(mario_x);
            m_py   = int'(mario_y);
            m_face = facing_left;
            if (airborne) begin m_state = 3; m_walk_n = 0; end
            else if (!walking) begin m_state = 0; m_walk_n = 0; end
            else begin
                m_walk_n++;
                m_state = (((m_walk_n - 1) / FPS) % 2) ? 2 : 1;
            end
        end
        #1;
        chk("rom_address", 32'(rom_address), 32'(e_addr));
        chk("rom_sel", 32'(rom_sel), 32'(e_sel));
        chk("sprite_on", 32'(sprite_on), 32'(e_on));
        chk("sprite_rgb", 32'(sprite_rgb), 32'(e_rgb));
    endtask

    task automatic tick(input int x, input int y, input bit w, input bit a, input bit f);
        mario_x = 10'(x); mario_y = 10'(y); walking = w; airborne = a; facing_left = f;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pix(input int x, input int y);
        DrawX = 10'(x); DrawY = 10'(y);
        step();
    endtask

    task automatic model_reset();
        m_px = 0; m_py = 0; m_face = 0; m_walk_n = 0; m_state = 0;
        p_hit = 0; p_addr = 0; p_sel = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_sprite_on", 32'(sprite_on), 32'd0);
        chk("reset_rom_sel", 32'(rom_sel), 32'd0);
        Reset = 1'b0;

        // Corner addresses of the box
        tick(100, 200, 0, 0, 0);
        ovr_en = 1'b1; ovr_col = 24'hF83800;
        pix(100, 200);
        chk("addr_top_left", 32'(rom_address), 32'd0);
        pix(120, 240);
        chk("addr_bottom_right", 32'(rom_address), 32'd860);
        pix(0, 0);
        chk("on_after_2", 32'(sprite_on), 32'd1);
        chk("rgb_after_2", 32'(sprite_rgb), 32'hF83800);
        ovr_col = TR;
        pix(110, 210);
        pix(0, 0);
        chk("key_on", 32'(sprite_on), 32'd0);
        chk("key_rgb", 32'(sprite_rgb), 32'd0);

        // Asynchronous reset while a sprite pixel is showing
        ovr_col = 24'hF83800;
        pix(110, 210);
        pix(111, 210);
        chk("pre_reset_on", 32'(sprite_on), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("async_on", 32'(sprite_on), 32'd0);
        chk("async_rgb", 32'(sprite_rgb), 32'd0);
        model_reset();
        @(posedge Clk);
        #1 Reset = 1'b0;
        DrawX = '0; DrawY = '0;
        step();
        chk("sel_after_reset", 32'(rom_sel), 32'd0);
        ovr_en = 1'b0;

        // Walk animation cadence, jump priority, stand
        for (int i = 0; i < 12; i++) begin
            tick(100, 200, 1, 0, 0);
            step();
            chk("walk_sel", 32'(rom_sel), (i < 6) ? 32'd1 : 32'd2);
        end
        tick(100, 200, 1, 1, 0);
        step();
        chk("jump_sel", 32'(rom_sel), 32'd3);
        tick(100, 200, 0, 0, 0);
        step();
        chk("stand_sel", 32'(rom_sel), 32'd0);

        // Edge clipping and box boundaries
        tick(1015, 300, 0, 0, 0);
        pix(1023, 300);
        chk("right_edge_hit", 32'(rom_address), 32'd8);
        for (int x = 0; x <= 5; x++) begin
            pix(x, 301);
            chk("no_wrap", 32'(rom_address), 32'd0);
        end
        tick(100, 200, 0, 0, 0);
        pix(99, 210);
        chk("left_miss", 32'(rom_address), 32'd0);
        pix(110, 241);
        chk("bottom_miss", 32'(rom_address), 32'd0);
        pix(110, 240);
        chk("bottom_row_hit", 32'(rom_address), 32'd850);

        // Mirroring
        tick(100, 200, 0, 0, 1);
        pix(100, 200);
`ifdef MARIO_FLIP_EN
        chk("flip_addr", 32'(rom_address), 32'd20);
`else
        chk("noflip_addr", 32'(rom_address), 32'd0);
`endif

        // Randomized frames and pixels around and away from the sprite
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                tick((($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023))),
                     (($urandom_range(0, 3) == 0) ? int'($urandom_range(980, 1023)) : int'($urandom_range(0, 1023))),
                     bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 3) != 0) begin
                pix((m_px + int'($urandom_range(0, 30)) - 5) & 1023, (m_py + int'($urandom_range(0, 50)) - 5) & 1023);
            end else begin
                pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
